bist_controller: RTL and testbench
==================================

BIST_CONTROLLER -- requirements
Module: bist_controller

Interface
REQ-001 Parameter NUM_PATTERNS, default 2000: number of scan patterns applied per BIST run; must be >= 1.
REQ-002 Parameter SHIFT_LEN, default 57: shift cycles per pattern (scan-chain depth); must be >= 1.
REQ-003 Parameter SEED_CYCLES, default 16: LFSR seeding cycles before the first pattern; must be >= 1.
REQ-004 Parameter SIG_W, default 16: MISR signature width.
REQ-005 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1: reset; asynchronous, active-high.
REQ-007 Port bistmode, input, 1: level request to run BIST; dropping it aborts.
REQ-008 Port misr_sig, input, SIG_W: current MISR contents.
REQ-009 Port golden_sig, input, SIG_W: fault-free signature, static during a run.
REQ-010 Port lfsr_en, output, 1: advance pattern LFSR this cycle.
REQ-011 Port misr_en, output, 1: compact cut_sdo into MISR this cycle.
REQ-012 Port misr_clear, output, 1: synchronously clear MISR this cycle.
REQ-013 Port cut_scanmode, output, 1: 1 = scan shift, 0 = functional capture.
REQ-014 Port busy, output, 1: high in any state other than IDLE and DONE.
REQ-015 Port bistdone, output, 1: run complete, held until bistmode drops.
REQ-016 Port bistpass, output, 1: valid while bistdone = 1; 1 = misr_sig matched golden_sig.

Function
REQ-017 FSM states SHALL be IDLE, SEED, SHIFT, CAPTURE, UNLOAD, COMPARE, DONE; all outputs decoded from registered state/counters.
REQ-018 IDLE -> SEED on a clock edge where bistmode = 1; bistpass cleared to 0 on that edge.
REQ-019 SEED lasts SEED_CYCLES cycles with lfsr_en = 1, misr_clear = 1, cut_scanmode = 0; then -> SHIFT.
REQ-020 SHIFT lasts SHIFT_LEN cycles with cut_scanmode = 1, lfsr_en = 1; misr_en = 1 only for pattern index >= 1 (first shift-out carries no response).
REQ-021 CAPTURE lasts 1 cycle, cut_scanmode = 0, lfsr_en = misr_en = 0; pattern counter increments; -> SHIFT if count < NUM_PATTERNS, else -> UNLOAD.
REQ-022 UNLOAD lasts SHIFT_LEN cycles with cut_scanmode = 1, misr_en = 1, lfsr_en = 0 (compacts the last response); then -> COMPARE.
REQ-023 COMPARE lasts 1 cycle; on its exit edge bistpass <= (misr_sig == golden_sig) and bistdone <= 1; -> DONE.
REQ-024 DONE holds bistdone = 1 and bistpass; -> IDLE when bistmode = 0; bistdone falls on that edge, bistpass holds its value until the next start.
REQ-025 bistmode = 0 in SEED/SHIFT/CAPTURE/UNLOAD/COMPARE SHALL abort to IDLE on the next edge, counters cleared, bistdone = 0, bistpass = 0.
REQ-026 Total cycles from the first SEED cycle to the first DONE cycle SHALL be SEED_CYCLES + NUM_PATTERNS*(SHIFT_LEN+1) + SHIFT_LEN + 1 (116074 at defaults).
REQ-027 Total misr_en cycles per run SHALL be NUM_PATTERNS*SHIFT_LEN; total lfsr_en cycles SEED_CYCLES + NUM_PATTERNS*SHIFT_LEN.
REQ-028 Counter widths SHALL be clog2 of their maximum value + 1; no wrap-around within a run.

Reset
REQ-029 rst = 1 SHALL immediately force IDLE, all counters 0, and all outputs 0, regardless of clk; rst takes priority over bistmode.
REQ-030 After rst falls, a run starts only on a later edge with bistmode = 1.

Structure
REQ-031 State encoding and the default parameter values SHALL reside in shared package bist_pkg.
REQ-032 One sub-module, bist_counter (loadable down-counter with terminal-count flag), SHALL be instantiated for both the phase and pattern counters.
REQ-033 Illegal parameter values (< 1) SHALL cause an elaboration error.

Verification (NUM_PATTERNS=3, SHIFT_LEN=4, SEED_CYCLES=2, SIG_W=16)
REQ-034 Start with golden_sig = misr_sig = 16'hA5C3 -> SEED cycles 0-1, CAPTUREs at cycles 6/11/16, UNLOAD 17-20, COMPARE 21, bistdone = 1, bistpass = 1 at cycle 22.
REQ-035 Same run with misr_sig = 16'hA5C2 -> bistdone = 1, bistpass = 0 at cycle 22.
REQ-036 Count enables over one run -> misr_en = 12 cycles, lfsr_en = 14 cycles, cut_scanmode = 16 cycles, misr_clear = 2 cycles.
REQ-037 Drop bistmode at cycle 9 -> IDLE at cycle 10, all outputs 0, bistdone never asserted; reassert -> full fresh run of 22 cycles.
REQ-038 Assert rst asynchronously mid-SHIFT -> outputs 0 before the next clk edge; rst held high with bistmode = 1 -> stays IDLE.
REQ-039 Hold bistmode = 1 in DONE for 10 cycles -> bistdone stays 1, no restart; drop bistmode -> bistdone = 0 next edge, bistpass retained.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared definitions for the BIST controller slice.
// Holds the FSM state encoding, default parameter values and a helper
// that sizes counters from their maximum value.
package bist_pkg;

  localparam int DEF_NUM_PATTERNS = 2000;
  localparam int DEF_SHIFT_LEN    = 57;
  localparam int DEF_SEED_CYCLES  = 16;
  localparam int DEF_SIG_W        = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_SHIFT,
    S_CAPTURE,
    S_UNLOAD,
    S_COMPARE,
    S_DONE
  } bist_state_t;

  // Bits needed to hold 0..max_val, never less than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/bist_counter.sv
// Loadable down-counter with terminal-count flag.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clr       - synchronous clear to zero (highest priority)
//   load      - load load_val
//   load_val  - value to load
//   dec       - decrement by one; holds at zero
//   count     - current value
//   tc        - terminal count, high when count is zero
module bist_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         tc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/bist_controller.sv
// Logic-BIST sequencer: seeds the pattern LFSR, shifts NUM_PATTERNS scan
// patterns through the CUT with a capture cycle after each, unloads the
// last response into the MISR, then compares the MISR against the golden
// signature.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   bistmode      - level run request; dropping it aborts a run
//   misr_sig      - current MISR contents
//   golden_sig    - expected fault-free signature
//   lfsr_en       - advance pattern LFSR
//   misr_en       - compact scan-out into MISR
//   misr_clear    - clear MISR
//   cut_scanmode  - 1 = scan shift, 0 = functional capture
//   busy          - run in progress
//   bistdone      - run complete, held until bistmode drops
//   bistpass      - signature matched (valid while bistdone)
module bist_controller
  import bist_pkg::*;
#(
  parameter int NUM_PATTERNS = DEF_NUM_PATTERNS,
  parameter int SHIFT_LEN    = DEF_SHIFT_LEN,
  parameter int SEED_CYCLES  = DEF_SEED_CYCLES,
  parameter int SIG_W        = DEF_SIG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bistmode,
  input  logic [SIG_W-1:0] misr_sig,
  input  logic [SIG_W-1:0] golden_sig,
  output logic             lfsr_en,
  output logic             misr_en,
  output logic             misr_clear,
  output logic             cut_scanmode,
  output logic             busy,
  output logic             bistdone,
  output logic             bistpass
);

  if (NUM_PATTERNS < 1) begin : g_bad_num_patterns
    $error("bist_controller: NUM_PATTERNS must be >= 1");
  end
  if (SHIFT_LEN < 1) begin : g_bad_shift_len
    $error("bist_controller: SHIFT_LEN must be >= 1");
  end
  if (SEED_CYCLES < 1) begin : g_bad_seed_cycles
    $error("bist_controller: SEED_CYCLES must be >= 1");
  end
  if (SIG_W < 1) begin : g_bad_sig_w
    $error("bist_controller: SIG_W must be >= 1");
  end

  localparam int PH_MAX = ((SEED_CYCLES > SHIFT_LEN) ? SEED_CYCLES : SHIFT_LEN) - 1;
  localparam int PH_W   = cnt_width(PH_MAX);
  localparam int PAT_W  = cnt_width(NUM_PATTERNS - 1);

  localparam logic [PH_W-1:0]  PH_SEED_LOAD  = PH_W'(SEED_CYCLES - 1);
  localparam logic [PH_W-1:0]  PH_SHIFT_LOAD = PH_W'(SHIFT_LEN - 1);
  localparam logic [PAT_W-1:0] PAT_LOAD      = PAT_W'(NUM_PATTERNS - 1);

  bist_state_t state, state_nxt;
  logic        done_nxt, pass_nxt;

  logic             ph_clr, ph_load, ph_dec, ph_tc;
  logic [PH_W-1:0]  ph_val, ph_count;
  logic             pat_clr, pat_load, pat_dec, pat_tc;
  logic [PAT_W-1:0] pat_count;
  logic             active;

  // Phase counter times SEED / SHIFT / UNLOAD; it is loaded with length-1
  // on entry so its terminal count marks the last cycle of the phase.
  bist_counter #(.W(PH_W)) u_phase_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (ph_clr),
    .load     (ph_load),
    .load_val (ph_val),
    .dec      (ph_dec),
    .count    (ph_count),
    .tc       (ph_tc)
  );

  // Pattern counter holds patterns still to apply after the current one;
  // its load value therefore identifies the first pattern.
  bist_counter #(.W(PAT_W)) u_pattern_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (pat_clr),
    .load     (pat_load),
    .load_val (PAT_LOAD),
    .dec      (pat_dec),
    .count    (pat_count),
    .tc       (pat_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      bistdone <= 1'b0;
      bistpass <= 1'b0;
    end else begin
      state    <= state_nxt;
      bistdone <= done_nxt;
      bistpass <= pass_nxt;
    end
  end

  assign active = (state != S_IDLE) && (state != S_DONE);

  always_comb begin
    state_nxt = state;
    done_nxt  = bistdone;
    pass_nxt  = bistpass;
    ph_clr    = 1'b0;
    ph_load   = 1'b0;
    ph_val    = PH_SHIFT_LOAD;
    ph_dec    = 1'b0;
    pat_clr   = 1'b0;
    pat_load  = 1'b0;
    pat_dec   = 1'b0;

    if (active && !bistmode) begin
      state_nxt = S_IDLE;
      ph_clr    = 1'b1;
      pat_clr   = 1'b1;
      done_nxt  = 1'b0;
      pass_nxt  = 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bistmode) begin
            state_nxt = S_SEED;
            ph_load   = 1'b1;
            ph_val    = PH_SEED_LOAD;
            pat_load  = 1'b1;
            done_nxt  = 1'b0;
            pass_nxt  = 1'b0;
          end
        end
        S_SEED: begin
          ph_dec = |ph_count;
          if (ph_tc) begin
            state_nxt = S_SHIFT;
            ph_load   = 1'b1;
          end
        end
        S_SHIFT: begin
          ph_dec = |ph_count;
          if (ph_tc) begin
            state_nxt = S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          ph_load = 1'b1;
          if (pat_tc) begin
            state_nxt = S_UNLOAD;
          end else begin
            state_nxt = S_SHIFT;
            pat_dec   = 1'b1;
          end
        end
        S_UNLOAD: begin
          ph_dec = |ph_count;
          if (ph_tc) begin
            state_nxt = S_COMPARE;
          end
        end
        S_COMPARE: begin
          state_nxt = S_DONE;
          done_nxt  = 1'b1;
          pass_nxt  = (misr_sig == golden_sig);
        end
        S_DONE: begin
          if (!bistmode) begin
            state_nxt = S_IDLE;
            done_nxt  = 1'b0;
            ph_clr    = 1'b1;
            pat_clr   = 1'b1;
          end
        end
        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    lfsr_en      = 1'b0;
    misr_en      = 1'b0;
    misr_clear   = 1'b0;
    cut_scanmode = 1'b0;
    busy         = active;
    unique case (state)
      S_SEED: begin
        lfsr_en    = 1'b1;
        misr_clear = 1'b1;
      end
      S_SHIFT: begin
        lfsr_en      = 1'b1;
        cut_scanmode = 1'b1;
        // The first pattern's shift-out is the uninitialised chain.
        misr_en      = (pat_count != PAT_LOAD);
      end
      S_UNLOAD: begin
        cut_scanmode = 1'b1;
        misr_en      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bist_controller.sv
module tb_bist_controller;

  localparam int NP = 3;
  localparam int SL = 4;
  localparam int SC = 2;
  localparam int SW = 16;
  localparam int SHIFT_END = SC + NP * (SL + 1);
  localparam int RUN_LEN   = SHIFT_END + SL + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          bistmode;
  logic [SW-1:0] misr_sig;
  logic [SW-1:0] golden_sig;
  logic          lfsr_en, misr_en, misr_clear, cut_scanmode, busy, bistdone, bistpass;
  logic [6:0]    obs;

  typedef struct {
    string      tag;
    logic [6:0] v;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   n_misr, n_lfsr, n_scan, n_clr;

  bist_controller #(
    .NUM_PATTERNS (NP),
    .SHIFT_LEN    (SL),
    .SEED_CYCLES  (SC),
    .SIG_W        (SW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bistmode     (bistmode),
    .misr_sig     (misr_sig),
    .golden_sig   (golden_sig),
    .lfsr_en      (lfsr_en),
    .misr_en      (misr_en),
    .misr_clear   (misr_clear),
    .cut_scanmode (cut_scanmode),
    .busy         (busy),
    .bistdone     (bistdone),
    .bistpass     (bistpass)
  );

  always #5 clk = ~clk;

  assign obs = {lfsr_en, misr_en, misr_clear, cut_scanmode, busy, bistdone, bistpass};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected {lfsr_en,misr_en,misr_clear,cut_scanmode,busy,bistdone,bistpass}
  // for cycle c of a run, c = 0 being the first SEED cycle.
  function automatic logic [6:0] run_vec(input int c, input logic pass);
    int off, p, r;
    if (c < SC) return 7'b1010100;
    if (c < SHIFT_END) begin
      off = c - SC;
      p   = off / (SL + 1);
      r   = off % (SL + 1);
      if (r < SL) return {1'b1, (p >= 1), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      return 7'b0000100;
    end
    if (c < SHIFT_END + SL) return 7'b0101100;
    if (c == SHIFT_END + SL) return 7'b0000100;
    return {5'b00000, 1'b1, pass};
  endfunction

  task automatic push_run(input int first, input int last, input logic pass);
    exp_t e;
    for (int c = first; c <= last; c++) begin
      e.tag = $sformatf("run_c%0d", c);
      e.v   = run_vec(c, pass);
      sb.push_back(e);
    end
  endtask

  task automatic push_const(input int n, input logic [6:0] v, input string tag);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.tag = $sformatf("%s_%0d", tag, i);
      e.v   = v;
      sb.push_back(e);
    end
  endtask

  task automatic drain(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      n_misr += int'(misr_en);
      n_lfsr += int'(lfsr_en);
      n_scan += int'(cut_scanmode);
      n_clr  += int'(misr_clear);
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check(e.tag, 32'(obs), 32'(e.v));
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    bistmode   = 1'b0;
    misr_sig   = 16'hA5C3;
    golden_sig = 16'hA5C3;
    n_misr = 0; n_lfsr = 0; n_scan = 0; n_clr = 0;

    // Reset state
    push_const(2, 7'b0000000, "reset");
    drain(2);
    rst = 1'b0;
    push_const(2, 7'b0000000, "idle_after_rst");
    drain(2);

    // Passing run, then holding bistmode in DONE for 10 cycles
    n_misr = 0; n_lfsr = 0; n_scan = 0; n_clr = 0;
    bistmode = 1'b1;
    push_run(0, RUN_LEN + 10, 1'b1);
    drain(RUN_LEN + 11);
    check("cnt_misr_en", 32'(n_misr), 32'd12);
    check("cnt_lfsr_en", 32'(n_lfsr), 32'd14);
    check("cnt_scanmode", 32'(n_scan), 32'd16);
    check("cnt_misr_clear", 32'(n_clr), 32'd2);
    bistmode = 1'b0;
    push_const(2, 7'b0000001, "drop_keep_pass");
    drain(2);

    // Failing signature; start edge clears the retained pass
    misr_sig = 16'hA5C2;
    bistmode = 1'b1;
    push_run(0, RUN_LEN, 1'b0);
    drain(RUN_LEN + 1);
    bistmode = 1'b0;
    push_const(2, 7'b0000000, "idle_after_fail");
    drain(2);

    // Abort in the middle of the second pattern's shift
    misr_sig = 16'hA5C3;
    bistmode = 1'b1;
    push_run(0, 9, 1'b1);
    drain(10);
    bistmode = 1'b0;
    push_const(3, 7'b0000000, "abort");
    drain(3);
    bistmode = 1'b1;
    push_run(0, RUN_LEN, 1'b1);
    drain(RUN_LEN + 1);
    bistmode = 1'b0;
    push_const(1, 7'b0000001, "idle_after_rerun");
    drain(1);

    // Asynchronous reset mid-SHIFT
    bistmode = 1'b1;
    push_run(0, 3, 1'b1);
    drain(4);
    #2 rst = 1'b1;
    #1 check("async_rst", 32'(obs), 32'd0);
    push_const(3, 7'b0000000, "rst_hold");
    drain(3);
    rst = 1'b0;
    push_run(0, RUN_LEN, 1'b1);
    drain(RUN_LEN + 1);
    bistmode = 1'b0;
    push_const(1, 7'b0000001, "idle_final");
    drain(1);

    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
